// File: rtl/vjtag_pkg.sv
// Shared definitions for the VJTAG host bus: command codes and the
// responder state encoding.
package vjtag_pkg;

   localparam logic [7:0] CMD_READ  = 8'h01;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_RST_A = 8'hFE;
   localparam logic [7:0] CMD_RST_D = 8'hFF;

   typedef enum logic [1:0] {
      RSP_IDLE,
      RSP_WAIT,
      RSP_ACCESS,
      RSP_RESP
   } rsp_state_t;

endpackage

// File: rtl/vjtag_bus_ram_mem.sv
// Single-port word RAM with registered read, shaped for M9K/M10K inference.
// Contents are never reset.
module vjtag_bus_ram_mem #(
  parameter int    DATA_WIDTH = 16,
  parameter int    DEPTH      = 1024,
  parameter int    IDXW       = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDXW-1:0]       i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/vjtag_bus_ram.sv
// VJTAG bus responder serving reads/writes from an on-chip word RAM, with a
// programmable number of busy cycles after each accepted request.
module vjtag_bus_ram
   import vjtag_pkg::*;
#(
   parameter int    ADDR_WIDTH  = 16,
   parameter int    DATA_WIDTH  = 16,
   parameter int    DEPTH       = 1024,
   parameter int    WAIT_CYCLES = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output rsp_state_t            o_dbg_state
);

   localparam int         OFFW     = $clog2(DATA_WIDTH / 8);
   localparam int         IDXW     = $clog2(DEPTH);
   localparam bit         HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [7:0] WAIT_M1  = HAS_WAIT ? 8'(WAIT_CYCLES - 1) : 8'd0;

   rsp_state_t            r_state;
   rsp_state_t            w_next;
   logic [7:0]            r_cnt;
   logic [IDXW-1:0]       r_idx;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [DATA_WIDTH-1:0] w_mem_q;
   logic                  w_accept;
   logic                  w_mem_we;
   logic                  w_mem_re;
   logic                  w_unused_addr;

   // Handshake: a request transfers on any rising edge where req_valid and
   // req_ready are both high; req_ready depends on state only, never on
   // req_valid. rsp_valid is a one-cycle pulse with no back-pressure.
   assign w_accept      = req_valid && req_ready;
   assign w_unused_addr = ^req_addr;
   assign o_dbg_state   = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RSP_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RSP_IDLE:   if (w_accept) w_next = HAS_WAIT ? RSP_WAIT : RSP_ACCESS;
         RSP_WAIT:   if (r_cnt == 8'd0) w_next = RSP_ACCESS;
         RSP_ACCESS: w_next = r_write ? RSP_IDLE : RSP_RESP;
         RSP_RESP:   w_next = RSP_IDLE;
         default:    w_next = RSP_IDLE;
      endcase
   end

   // A write still in ACCESS when rst arrives must not reach the RAM.
   always_comb begin
      req_ready = (r_state == RSP_IDLE);
      rsp_valid = (r_state == RSP_RESP);
      rsp_rdata = (r_state == RSP_RESP) ? w_mem_q : r_rsp_rdata;
      w_mem_we  = (r_state == RSP_ACCESS) && r_write && !rst;
      w_mem_re  = (r_state == RSP_ACCESS) && !r_write;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= 8'd0;
         r_idx       <= '0;
         r_write     <= 1'b0;
         r_wdata     <= '0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_idx   <= req_addr[OFFW +: IDXW];
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_cnt   <= WAIT_M1;
         end else if (r_state == RSP_WAIT && r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
         end
         if (r_state == RSP_RESP) begin
            r_rsp_rdata <= w_mem_q;
         end
      end
   end

   vjtag_bus_ram_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDXW       (IDXW),
      .INIT_FILE  (INIT_FILE)
   ) u_mem (
      .i_clk   (clk),
      .i_we    (w_mem_we),
      .i_re    (w_mem_re),
      .i_addr  (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_q)
   );

endmodule

// File: tb/tb_vjtag_bus_ram.sv
// Directed and table-driven bench for vjtag_bus_ram: a WAIT_CYCLES=2 instance
// (index 0) and a WAIT_CYCLES=0 instance (index 1) share clock and reset.
module tb_vjtag_bus_ram;
   import vjtag_pkg::*;

   typedef struct {
      bit          w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        req_write [2];
   logic [15:0] req_addr  [2];
   logic [15:0] req_wdata [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [15:0] rsp_rdata [2];
   rsp_state_t  dbg       [2];

   int          n_total = 0;
   int          n_bad   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] ref_mem [64];
   vec_t        tbl [10];

   always #5 clk = ~clk;

   vjtag_bus_ram #(.WAIT_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
      .req_write(req_write[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .o_dbg_state(dbg[0])
   );

   vjtag_bus_ram #(.WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
      .req_write(req_write[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .o_dbg_state(dbg[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one request on instance s from a negedge; returns at the negedge of
   // the completion cycle (write: ready back; read: cycle after the pulse).
   task automatic xact(input int s, input bit w, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] rd, output int lat);
      req_valid[s] = 1'b1;
      req_write[s] = w;
      req_addr[s]  = a;
      req_wdata[s] = d;
      @(posedge clk);
      #1;
      req_valid[s] = 1'b0;
      lat = -1;
      rd  = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (w ? req_ready[s] : rsp_valid[s]) begin
            lat = c;
            rd  = rsp_rdata[s];
            break;
         end
      end
      if (!w && lat > 0) begin
         chk("ready_low_in_resp", 32'(req_ready[s]), 32'd0);
         @(negedge clk);
         chk("rsp_pulse_width", 32'(rsp_valid[s]), 32'd0);
         chk("ready_after_resp", 32'(req_ready[s]), 32'd1);
      end
   endtask

   task automatic wait_ready(input int s);
      bit ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_ready[s]) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_ready_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      int          lat;
      int          acc;
      int          pulses;

      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req_valid[s] = 1'b0;
         req_write[s] = 1'b0;
         req_addr[s]  = '0;
         req_wdata[s] = '0;
      end

      tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
      tbl[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
      tbl[2] = '{1'b1, 16'h0040, 16'hCAFE, 16'h0000};
      tbl[3] = '{1'b1, 16'h0042, 16'h1357, 16'h0000};
      tbl[4] = '{1'b0, 16'h0041, 16'h0000, 16'hCAFE};
      tbl[5] = '{1'b0, 16'h0043, 16'h0000, 16'h1357};
      tbl[6] = '{1'b0, 16'h0040, 16'h0000, 16'hCAFE};
      tbl[7] = '{1'b1, 16'h0810, 16'hA5A5, 16'h0000};
      tbl[8] = '{1'b0, 16'h0011, 16'h0000, 16'hA5A5};
      tbl[9] = '{1'b0, 16'hF811, 16'h0000, 16'hA5A5};

      // Reset held for three edges, then released.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            chk("reset_ready", 32'(req_ready[s]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[s]), 32'd0);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("post_reset_ready", 32'(req_ready[s]), 32'd1);
         chk("post_reset_rsp_valid", 32'(rsp_valid[s]), 32'd0);
         chk("post_reset_rdata", 32'(rsp_rdata[s]), 32'd0);
         chk("post_reset_state", 32'(dbg[s]), 32'(RSP_IDLE));
      end

      // Table of back-to-back transactions on the two-wait-state instance.
      for (int i = 0; i < 10; i++) begin
         xact(0, tbl[i].w, tbl[i].a, tbl[i].d, rd, lat);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd4);
         if (!tbl[i].w) chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp));
      end

      // Reset during WAIT drops the read response; RAM survives reset.
      xact(0, 1'b1, 16'h0010, 16'hBEEF, rd, lat);
      chk("rst_prewrite_latency", 32'(lat), 32'd4);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b0;
      req_addr[0]  = 16'h0010;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pulses = 0;
      @(negedge clk);
      chk("rst_mid_state", 32'(dbg[0]), 32'(RSP_IDLE));
      chk("rst_mid_ready", 32'(req_ready[0]), 32'd1);
      for (int c = 0; c < 8; c++) begin
         if (rsp_valid[0]) pulses++;
         @(negedge clk);
      end
      chk("rst_mid_no_rsp", 32'(pulses), 32'd0);
      xact(0, 1'b0, 16'h0010, 16'h0000, rd, lat);
      chk("rst_mid_reread_data", 32'(rd), 32'hBEEF);
      chk("rst_mid_reread_latency", 32'(lat), 32'd4);

      // Backpressure: second request held valid from cycle 1.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 16'h0030;
      req_wdata[0] = 16'h5555;
      @(posedge clk);
      #1;
      req_addr[0]  = 16'h0020;
      req_wdata[0] = 16'h1234;
      acc = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (req_ready[0]) begin
            acc = c;
            break;
         end
      end
      chk("bp_accept_cycle", 32'(acc), 32'd4);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("bp_busy_after_accept", 32'(req_ready[0]), 32'd0);
      wait_ready(0);
      xact(0, 1'b0, 16'h0020, 16'h0000, rd, lat);
      chk("bp_read_0020", 32'(rd), 32'h1234);
      xact(0, 1'b0, 16'h0030, 16'h0000, rd, lat);
      chk("bp_read_0030", 32'(rd), 32'h5555);

      // Zero-wait instance: back-to-back writes then a read.
      for (int i = 0; i < 4; i++) begin
         xact(1, 1'b1, 16'(2 * i), 16'(16'h1111 * (i + 1)), rd, lat);
         chk($sformatf("w0_write%0d_latency", i), 32'(lat), 32'd2);
      end
      xact(1, 1'b0, 16'h0004, 16'h0000, rd, lat);
      chk("w0_read_latency", 32'(lat), 32'd2);
      chk("w0_read_data", 32'(rd), 32'h3333);

      // Random mix against a reference memory over 64 words with aliasing.
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = 16'($urandom_range(0, 65535));
         xact(1, 1'b1, 16'(2 * i), ref_mem[i], rd, lat);
      end
      for (int n = 0; n < 1000; n++) begin
         int          idx;
         bit          w;
         logic [15:0] a;
         logic [15:0] d;
         idx = $urandom_range(0, 63);
         w   = 1'($urandom_range(0, 1));
         d   = 16'($urandom_range(0, 65535));
         a   = {5'($urandom_range(0, 31)), 4'b0000, 6'(idx), 1'($urandom_range(0, 1))};
         if (w) begin
            ref_mem[idx] = d;
            xact(1, 1'b1, a, d, rd, lat);
         end else begin
            exp_q.push_back(ref_mem[idx]);
            xact(1, 1'b0, a, 16'h0000, rd, lat);
            chk("rand_read_data", 32'(rd), 32'(exp_q.pop_front()));
         end
         chk("rand_latency", 32'(lat), 32'd2);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
